// File: rtl/fp_add_pkg.sv
// Shared definitions for the pipelined floating-point adder:
// flag bit positions, the special-case payload carried down the pipe,
// and a helper producing the canonical quiet NaN for any format.
package fp_add_pkg;

  // Bit positions inside out_flags = {invalid, overflow, underflow, inexact}
  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INVALID   = 3;

  // Special-operand outcome decided in S1 and carried unchanged to S3.
  // hit: result is fully determined by NaN/inf operands.
  typedef struct packed {
    logic hit;
    logic nan;
    logic sign;
    logic invalid;
  } spec_t;

  // Canonical NaN: sign 0, exponent all ones, fraction MSB set, rest clear.
  // Returned right-aligned in 64 bits; callers take the low 1+exp_w+man_w.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter. cnt = number of zeros above the highest set bit,
// or W when the input is all zero.
module fp_lzc #(
  parameter  int W  = 27,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_vec,
  output logic [CW-1:0] cnt
);

  // Scan upward so the highest set bit makes the last (winning) assignment
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++)
      if (in_vec[i]) cnt = CW'(W - 1 - i);
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-style adder/subtractor with round-to-nearest-even.
//   S1: unpack, NaN/inf detection, magnitude swap, alignment with G/R/S
//   S2: mantissa add/subtract, leading-zero normalisation
//   S3: RNE rounding, overflow/underflow handling, pack
// All stages advance together on adv = out_ready | ~out_valid.
// Build option: define FP_ADD_SUBNORM_EN for gradual underflow; without
// it subnormal inputs read as signed zero and tiny results flush to zero.
module fp_add_pipe
  import fp_add_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags
);

  localparam int MW4 = MAN_W + 4;          // hidden + fraction + G/R/S
  localparam int MW5 = MAN_W + 5;          // plus carry-out of the add
  localparam int CW  = $clog2(MW4 + 1);
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [63:0]    NAN64   = canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]   QNAN    = NAN64[W-1:0];

  logic       adv;
  logic [2:0] vld_pipe;

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[2];

  // ---------------- S1: unpack / special detect / align ----------------
  logic             sa, sb, ha, hb;
  logic             nan_a, nan_b, inf_a, inf_b;
  logic [EXP_W-1:0] ea, eb, xa, xb;
  logic [MAN_W-1:0] fa, fb, fa_u, fb_u;

  assign sa    = in_a[W-1];
  assign ea    = in_a[W-2:MAN_W];
  assign fa    = in_a[MAN_W-1:0];
  assign sb    = in_b[W-1] ^ in_sub;
  assign eb    = in_b[W-2:MAN_W];
  assign fb    = in_b[MAN_W-1:0];
  assign nan_a = (&ea) & (|fa);
  assign nan_b = (&eb) & (|fb);
  assign inf_a = (&ea) & ~(|fa);
  assign inf_b = (&eb) & ~(|fb);
  assign ha    = |ea;
  assign hb    = |eb;
  // Zero-exponent operands sit at effective exponent 1
  assign xa    = ha ? ea : EXP_W'(1);
  assign xb    = hb ? eb : EXP_W'(1);
`ifdef FP_ADD_SUBNORM_EN
  assign fa_u  = fa;
  assign fb_u  = fb;
`else
  assign fa_u  = ha ? fa : '0;
  assign fb_u  = hb ? fb : '0;
`endif

  logic             a_big, s_big;
  logic [EXP_W-1:0] x_big, x_sm, d;
  logic [MAN_W:0]   m_big, m_sm;
  logic [MW4-1:0]   ext_sm, sh_sm, al_sm;
  spec_t            spec1;

  // Raw {exp,frac} order equals magnitude order; ties keep A on top
  assign a_big = {ea, fa_u} >= {eb, fb_u};

  // Swap so the larger magnitude is on top, then shift the smaller right
  // keeping G/R and OR-ing everything below R into the sticky position
  always_comb begin
    if (a_big) begin
      s_big = sa; x_big = xa; m_big = {ha, fa_u}; x_sm = xb; m_sm = {hb, fb_u};
    end else begin
      s_big = sb; x_big = xb; m_big = {hb, fb_u}; x_sm = xa; m_sm = {ha, fa_u};
    end
    d      = x_big - x_sm;
    ext_sm = {m_sm, 3'b000};
    sh_sm  = ext_sm >> d;
    if (32'(d) >= 32'(MAN_W + 3))
      al_sm = {{(MW4-1){1'b0}}, |m_sm};
    else
      al_sm = sh_sm | {{(MW4-1){1'b0}}, |(ext_sm & ~({MW4{1'b1}} << d))};
  end

  // NaN beats everything; inf-inf of opposite effective signs is invalid
  always_comb begin
    spec1.hit     = nan_a | nan_b | inf_a | inf_b;
    spec1.nan     = nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
    spec1.invalid = ~(nan_a | nan_b) & inf_a & inf_b & (sa ^ sb);
    spec1.sign    = inf_a ? sa : sb;
  end

  logic             s1_sign, s1_sub;
  logic [EXP_W-1:0] s1_exp;
  logic [MW4-1:0]   s1_mbig, s1_msm;
  spec_t            s1_spec;

  // S1 payload register
  always_ff @(posedge clk)
    if (adv) begin
      s1_sign <= s_big;
      s1_sub  <= sa ^ sb;
      s1_exp  <= x_big;
      s1_mbig <= {m_big, 3'b000};
      s1_msm  <= al_sm;
      s1_spec <= spec1;
    end

  // ---------------- S2: add / normalise ----------------
  logic [MW5-1:0]   sum;
  logic [CW-1:0]    lz;
  logic [MW4-1:0]   norm;
  logic [EXP_W:0]   n_exp;
  logic             n_tiny;

  assign sum = s1_sub ? ({1'b0, s1_mbig} - {1'b0, s1_msm})
                      : ({1'b0, s1_mbig} + {1'b0, s1_msm});

  fp_lzc #(.W(MW4)) u_lzc (.in_vec(sum[MW4-1:0]), .cnt(lz));

  // Carry: shift right one folding the dropped bit into sticky.
  // Otherwise shift left by the leading-zero count, but never below exp 1.
  always_comb begin
    norm   = sum[MW4-1:0];
    n_exp  = {1'b0, s1_exp};
    n_tiny = 1'b0;
    if (sum[MW4]) begin
      norm  = {sum[MW4:2], |sum[1:0]};
      n_exp = {1'b0, s1_exp} + (EXP_W+1)'(1);
    end else if (32'(lz) < 32'(s1_exp)) begin
      norm  = sum[MW4-1:0] << lz;
      n_exp = {1'b0, s1_exp} - (EXP_W+1)'(lz);
    end else begin
`ifdef FP_ADD_SUBNORM_EN
      norm  = sum[MW4-1:0] << (s1_exp - EXP_W'(1));
      n_exp = '0;
`else
      norm   = '0;
      n_exp  = '0;
      n_tiny = 1'b1;
`endif
    end
  end

  logic             s2_sign, s2_sub, s2_zero, s2_tiny;
  logic [EXP_W:0]   s2_exp;
  logic [MW4-1:0]   s2_man;
  spec_t            s2_spec;

  // S2 payload register
  always_ff @(posedge clk)
    if (adv) begin
      s2_sign <= s1_sign;
      s2_sub  <= s1_sub;
      s2_zero <= (sum == '0);
      s2_tiny <= n_tiny;
      s2_exp  <= n_exp;
      s2_man  <= norm;
      s2_spec <= s1_spec;
    end

  // ---------------- S3: round / pack ----------------
  logic [MAN_W:0]   m;
  logic [MAN_W+1:0] rm;
  logic             g, r, st, inex, rup;
  logic [EXP_W:0]   e_out;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res;
  logic [3:0]       flg;

  assign m    = s2_man[MW4-1:3];
  assign g    = s2_man[2];
  assign r    = s2_man[1];
  assign st   = s2_man[0];
  assign inex = g | r | st;
  assign rup  = g & (r | st | m[0]);
  assign rm   = {1'b0, m} + (MAN_W+2)'(rup);

  // RNE increment; a subnormal that rounds up into the hidden bit becomes
  // exponent 1, a normal whose mantissa overflows bumps the exponent
  always_comb begin
    e_out = s2_exp;
    frac  = rm[MAN_W-1:0];
    if (s2_exp == '0)
      e_out = {{EXP_W{1'b0}}, rm[MAN_W]};
    else if (rm[MAN_W+1]) begin
      e_out = s2_exp + (EXP_W+1)'(1);
      frac  = '0;
    end
  end

  // Result selection in priority order: special, exact zero, flush, overflow
  always_comb begin
    res = {s2_sign, e_out[EXP_W-1:0], frac};
    flg = '0;
    if (s2_spec.hit) begin
      res = s2_spec.nan ? QNAN : {s2_spec.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg[FLG_INVALID] = s2_spec.invalid;
    end else if (s2_zero) begin
      res = {s2_sign & ~s2_sub, {(W-1){1'b0}}};
    end else if (s2_tiny) begin
      res = {s2_sign, {(W-1){1'b0}}};
      flg[FLG_UNDERFLOW] = 1'b1;
      flg[FLG_INEXACT]   = 1'b1;
    end else if (e_out >= EXP_MAX) begin
      res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg[FLG_OVERFLOW] = 1'b1;
      flg[FLG_INEXACT]  = 1'b1;
    end else begin
      flg[FLG_INEXACT]   = inex;
      flg[FLG_UNDERFLOW] = (e_out == '0) & inex;
    end
  end

  // Output register; holds while downstream stalls
  always_ff @(posedge clk)
    if (rst) begin
      out_result <= '0;
      out_flags  <= '0;
    end else if (adv) begin
      out_result <= res;
      out_flags  <= flg;
    end

  // Stage valid shift register; reset drops everything in flight
  always_ff @(posedge clk)
    if (rst)      vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[1:0], in_valid};

endmodule

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (range 4..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width excluding hidden bit (range 3..52).
REQ-003 SHALL define W = 1+EXP_W+MAN_W as a derived localparam, not a parameter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair present.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 in_a  input  W  operand A, IEEE-style {sign, exp, frac}.
REQ-009 in_b  input  W  operand B.
REQ-010 in_sub  input  1  0: A+B; 1: A-B (B sign inverted before processing).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_result  output  W  rounded sum.
REQ-014 out_flags  output  4  {invalid, overflow, underflow, inexact}, aligned with out_result.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/special detect/align; S2 signed mantissa add plus leading-zero normalise; S3 round-to-nearest-even and pack.
REQ-016 Latency SHALL be exactly 3 cycles from an accepting edge (in_valid & in_ready) to out_valid with no stall.
REQ-017 Pipeline SHALL advance when adv = out_ready | ~out_valid. in_ready SHALL equal adv. When adv=0, all stage registers SHALL hold.
REQ-018 Sustained throughput SHALL be one result per cycle while out_ready=1.
REQ-019 Results SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-020 out_result and out_flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 Alignment SHALL keep guard, round and sticky bits. Sticky SHALL be the OR of all bits shifted past round. Shift amounts of MAN_W+3 or more SHALL saturate to a pure sticky.
REQ-022 Effective subtraction SHALL subtract the smaller magnitude from the larger. Result sign SHALL be the sign of the larger magnitude.
REQ-023 An exact zero result of x-x SHALL be +0. (-0)+(-0) SHALL give -0.
REQ-024 Rounding SHALL be RNE. A mantissa carry-out from rounding SHALL increment the exponent.
REQ-025 Any NaN input SHALL give canonical NaN: sign 0, exponent all ones, fraction MSB 1, rest 0.
REQ-026 inf-inf (effective) SHALL give canonical NaN with invalid=1.
REQ-027 inf plus finite SHALL give that inf with flags 0.
REQ-028 Exponent at or beyond all-ones after rounding SHALL give signed inf with overflow=1 and inexact=1.
REQ-029 inexact SHALL be 1 iff any of guard, round or sticky is nonzero before rounding.
REQ-030 underflow SHALL be 1 iff the result is tiny after rounding and inexact.

Reset
REQ-031 While rst=1, the valid bits of all stages SHALL clear on the next edge.
REQ-032 Reset values: out_valid=0, out_result=0, out_flags=0. in_ready SHALL be 1 in the first cycle after reset.
REQ-033 Reset mid-operation SHALL discard all in-flight operations. No result from before reset SHALL appear afterwards.

Configuration
REQ-034 With macro FP_ADD_SUBNORM_EN defined, subnormal inputs SHALL be used with hidden bit 0 and effective exponent 1, and subnormal results SHALL be produced with gradual underflow.
REQ-035 Without FP_ADD_SUBNORM_EN, subnormal inputs SHALL be treated as signed zero and tiny results SHALL flush to signed zero with underflow=1 and inexact=1. Datapath latency SHALL be identical in both builds.

Structure
REQ-036 Package fp_add_pkg SHALL hold the flag-index constants, a stage-payload struct typedef, and a function returning canonical NaN for given EXP_W/MAN_W.
REQ-037 Sub-module fp_lzc SHALL be a parametrised leading-zero counter (input width MAN_W+4), instantiated in S2.

Verification
REQ-038 0x3F800000 + 0x3F800000, in_sub=0 -> 0x40000000, flags 0000, out_valid exactly 3 cycles after acceptance.
REQ-039 0x3F800001 + 0x33800000 (exact tie) -> 0x3F800002, inexact=1; 0x3F800000 + 0x33800000 -> 0x3F800000, inexact=1.
REQ-040 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1; 0x7F800000 - 0x7F800000 (in_sub=1) -> 0x7FC00000, invalid=1.
REQ-041 0x40400000 - 0x40400000 -> 0x00000000; 0x80000000 + 0x80000000 -> 0x80000000.
REQ-042 Four back-to-back operations with out_ready held 0 for 5 cycles -> in_ready drops after the pipeline fills, all four results emerge in order, none lost; rst asserted with 2 in flight -> out_valid=0 next cycle and those results are never emitted.
REQ-043 0x00000001 + 0x00000001 -> 0x00000002 with FP_ADD_SUBNORM_EN defined; -> 0x00000000 without it.
